// File: rtl/ct_spsram_acc_ctrl.sv
// ct_spsram_acc_ctrl: valid/ready access controller for a single-port SRAM macro wrapper.
// Define SPSRAM_ACC_INIT_EN to clear the whole array after reset before accepting requests.
//
// state | meaning
// INIT  | sweeping every address with a zero write; requests blocked (SPSRAM_ACC_INIT_EN only)
// RUN   | accepting requests while response credits remain
module ct_spsram_acc_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic                  run;
    logic                  init_wr;
    logic [ADDR_WIDTH-1:0] init_addr;

`ifdef SPSRAM_ACC_INIT_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic                  live_q, live_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

    // live_q holds the sweep off for the first cycle after release so the pins stay idle.
    always_comb begin
        state_d    = state_q;
        live_d     = 1'b1;
        init_cnt_d = init_cnt_q;
        if (live_q && (state_q == ST_INIT)) begin
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
            if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= ST_INIT;
            live_q     <= 1'b0;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            live_q     <= live_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign run       = (state_q == ST_RUN);
    assign init_wr   = live_q && (state_q == ST_INIT);
    assign init_addr = init_cnt_q;
`else
    logic run_q, run_d;

    assign run_d = 1'b1;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

    assign run       = run_q;
    assign init_wr   = 1'b0;
    assign init_addr = '0;
`endif

    assign init_done = run;

    logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
    logic                  inflight_q, inflight_d;
    logic [CW-1:0]         occ;
    logic                  acc;
    logic                  push;
    logic                  pop;

    // A read holds a FIFO slot from accept onward, so credits count the in-flight read too.
    assign occ      = fifo_cnt_q + CW'(inflight_q);
    assign req_rdy  = run && (occ < DEPTH_C);
    assign acc      = req_vld && req_rdy;
    assign push     = inflight_q;
    assign rsp_vld  = (fifo_cnt_q != '0);
    assign pop      = rsp_vld && rsp_rdy;
    assign rsp_data = rsp_vld ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        inflight_d = acc && !req_wr;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        mem_d      = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = sram_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: rsp_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge forever_cpuclk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst_b) begin
            assert (!(push && !pop && (fifo_cnt_q == DEPTH_C)));
        end
    end

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (init_wr) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_addr;
        end else if (acc) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            if (req_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_wmask;
                sram_d    = req_wdata;
            end
        end
    end

endmodule
